// File: rtl/booth_pkg.sv
// Shared widths, constants and pipeline record types for the Booth
// multiply-accumulate back end.
package booth_pkg;

  localparam int PP_ROW0_W = 11;
  localparam int PP_ROW_W  = 9;
  localparam int PROD_W    = 16;
  localparam int N_ROWS    = 4;
  localparam int N_ADDENDS = 9;

  // Sign-extension correction folded into one constant instead of per-row ones.
  localparam logic [PROD_W-1:0] SEXT_K = 16'hA800;

  localparam logic [N_ROWS-1:0][3:0] ROW_SHIFT = {4'd6, 4'd4, 4'd2, 4'd0};

  typedef struct packed {
    logic              valid;
    logic              last;
    logic [PROD_W-1:0] sum;
    logic [PROD_W-1:0] carry;
  } s1_t;

  typedef struct packed {
    logic              valid;
    logic              last;
    logic [PROD_W-1:0] prod;
  } s2_t;

  function automatic logic [PROD_W-1:0] place_row(input logic [PP_ROW0_W-1:0] row,
                                                  input logic [3:0]           shift);
    return {{(PROD_W-PP_ROW0_W){1'b0}}, row} << shift;
  endfunction

endpackage

// File: rtl/csa_3to2.sv
// Parameterised 3:2 carry-save compressor; carry is returned already
// shifted into its weight position, truncated to W bits.
module csa_3to2 #(
  parameter int W = 16
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_c,
  output logic [W-1:0] o_sum,
  output logic [W-1:0] o_carry
);

  logic [W-2:0] w_maj;

  assign o_sum   = i_a ^ i_b ^ i_c;
  assign w_maj   = (i_a[W-2:0] & i_b[W-2:0]) | (i_a[W-2:0] & i_c[W-2:0]) |
                   (i_b[W-2:0] & i_c[W-2:0]);
  assign o_carry = {w_maj, 1'b0};

endmodule

// File: rtl/pp_accumulator.sv
// Booth partial-product reduction into a 16-bit product, followed by a
// saturating burst accumulator with a valid/ready result port.
module pp_accumulator
  import booth_pkg::*;
#(
  parameter int ACC_W = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_last,
  input  logic [PP_ROW0_W-1:0] pp0,
  input  logic [PP_ROW_W-1:0]  pp1,
  input  logic [PP_ROW_W-1:0]  pp2,
  input  logic [PP_ROW_W-1:0]  pp3,
  input  logic                 neg0,
  input  logic                 neg1,
  input  logic                 neg2,
  input  logic                 neg3,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_W-1:0]     out_acc,
  output logic                 out_ovf
);

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [PROD_W-1:0]    w_add [N_ADDENDS];
  logic [PROD_W-1:0]    w_l1  [6];
  logic [PROD_W-1:0]    w_l2  [4];
  logic [PROD_W-1:0]    w_l3  [3];
  logic [PROD_W-1:0]    w_s;
  logic [PROD_W-1:0]    w_c;
  logic [PP_ROW_W-1:0]  w_rows [1:N_ROWS-1];
  logic [N_ROWS-1:0]    w_neg;
  logic                 w_adv;

  s1_t                  r_s1;
  s2_t                  r_s2;
  logic [ACC_W-1:0]     r_acc;
  logic                 r_first;
  logic                 r_ovf;
  logic                 r_out_valid;
  logic [ACC_W-1:0]     r_out_acc;
  logic                 r_out_ovf;

  logic [ACC_W:0]       w_p_ext;
  logic [ACC_W:0]       w_acc_ext;
  logic [ACC_W:0]       w_sum;
  logic                 w_clip;
  logic [ACC_W-1:0]     w_sat;

  assign w_rows[1] = pp1;
  assign w_rows[2] = pp2;
  assign w_rows[3] = pp3;
  assign w_neg     = {neg3, neg2, neg1, neg0};

  // Addend order: rows 0..3, negate bits 0..3, correction constant.
  assign w_add[0] = place_row(pp0, ROW_SHIFT[0]);
  generate
    for (genvar gi = 1; gi < N_ROWS; gi++) begin : g_rows
      assign w_add[gi] = place_row({2'b00, w_rows[gi]}, ROW_SHIFT[gi]);
    end
    for (genvar gi = 0; gi < N_ROWS; gi++) begin : g_negs
      assign w_add[N_ROWS+gi] = place_row({{(PP_ROW0_W-1){1'b0}}, w_neg[gi]}, ROW_SHIFT[gi]);
    end
  endgenerate
  assign w_add[N_ADDENDS-1] = SEXT_K;

  // Wallace-style tree: 9 -> 6 -> 4 -> 3 -> 2.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_lvl1
      csa_3to2 #(.W(PROD_W)) u_csa (
        .i_a(w_add[3*gi]), .i_b(w_add[3*gi+1]), .i_c(w_add[3*gi+2]),
        .o_sum(w_l1[2*gi]), .o_carry(w_l1[2*gi+1])
      );
    end
    for (genvar gi = 0; gi < 2; gi++) begin : g_lvl2
      csa_3to2 #(.W(PROD_W)) u_csa (
        .i_a(w_l1[3*gi]), .i_b(w_l1[3*gi+1]), .i_c(w_l1[3*gi+2]),
        .o_sum(w_l2[2*gi]), .o_carry(w_l2[2*gi+1])
      );
    end
  endgenerate

  csa_3to2 #(.W(PROD_W)) u_csa_lvl3 (
    .i_a(w_l2[0]), .i_b(w_l2[1]), .i_c(w_l2[2]),
    .o_sum(w_l3[0]), .o_carry(w_l3[1])
  );
  assign w_l3[2] = w_l2[3];

  csa_3to2 #(.W(PROD_W)) u_csa_lvl4 (
    .i_a(w_l3[0]), .i_b(w_l3[1]), .i_c(w_l3[2]),
    .o_sum(w_s), .o_carry(w_c)
  );

  assign w_adv    = ~r_out_valid | out_ready;
  assign in_ready = w_adv;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else if (w_adv) begin
      r_s1.valid <= in_valid;
      r_s1.last  <= in_last;
      r_s1.sum   <= w_s;
      r_s1.carry <= w_c;
      r_s2.valid <= r_s1.valid;
      r_s2.last  <= r_s1.last;
      r_s2.prod  <= r_s1.sum + r_s1.carry;
    end
  end

  // One guard bit above ACC_W is enough: |P| never exceeds 2^(ACC_W-1).
  assign w_p_ext   = {{(ACC_W+1-PROD_W){r_s2.prod[PROD_W-1]}}, r_s2.prod};
  assign w_acc_ext = r_first ? '0 : {r_acc[ACC_W-1], r_acc};
  assign w_sum     = w_acc_ext + w_p_ext;
  assign w_clip    = w_sum[ACC_W] ^ w_sum[ACC_W-1];
  assign w_sat     = w_clip ? (w_sum[ACC_W] ? ACC_MIN : ACC_MAX) : w_sum[ACC_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc       <= '0;
      r_first     <= 1'b1;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_acc   <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      if (w_adv && r_s2.valid) begin
        r_acc <= w_sat;
        if (r_s2.last) begin
          r_first   <= 1'b1;
          r_ovf     <= 1'b0;
          r_out_acc <= w_sat;
          r_out_ovf <= r_ovf | w_clip;
        end else begin
          r_first <= 1'b0;
          r_ovf   <= r_ovf | w_clip;
        end
      end
      if (w_adv && r_s2.valid && r_s2.last)
        r_out_valid <= 1'b1;
      else if (out_ready)
        r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_acc   = r_out_acc;
  assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_pp_accumulator.sv
// Bench for pp_accumulator: a Booth PPG model feeds two instances (ACC_W 20
// and 16); results are scored against a plain-arithmetic burst sum model.
module tb_pp_accumulator;

  typedef struct packed {
    logic [10:0] pp0;
    logic [8:0]  pp1;
    logic [8:0]  pp2;
    logic [8:0]  pp3;
    logic [3:0]  neg;
  } ppg_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid_drv = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready_man = 1'b1;
  logic        rand_ready = 1'b0;
  logic        rnd_ready = 1'b1;
  logic        sel16 = 1'b0;
  logic [10:0] pp0 = '0;
  logic [8:0]  pp1 = '0, pp2 = '0, pp3 = '0;
  logic [3:0]  negv = '0;

  logic        in_valid_a, in_valid_b, out_ready;
  logic        in_ready_a, out_valid_a, out_ovf_a;
  logic        in_ready_b, out_valid_b, out_ovf_b;
  logic [19:0] out_acc_a;
  logic [15:0] out_acc_b;
  logic        in_ready_s, out_valid_s, out_ovf_s;
  int          out_acc_s;

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;

  int exp_acc[$];
  bit exp_ovf[$];
  int obs_acc[$];
  bit obs_ovf[$];
  int obs_cyc[$];

  int m_acc = 0;
  bit m_ovf = 1'b0;
  bit m_first = 1'b1;
  int acc_w = 20;

  assign in_valid_a  = in_valid_drv & ~sel16;
  assign in_valid_b  = in_valid_drv & sel16;
  assign out_ready   = rand_ready ? rnd_ready : out_ready_man;
  assign in_ready_s  = sel16 ? in_ready_b : in_ready_a;
  assign out_valid_s = sel16 ? out_valid_b : out_valid_a;
  assign out_ovf_s   = sel16 ? out_ovf_b : out_ovf_a;
  assign out_acc_s   = sel16 ? int'($signed(out_acc_b)) : int'($signed(out_acc_a));

  pp_accumulator #(.ACC_W(20)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_last(in_last), .pp0(pp0), .pp1(pp1), .pp2(pp2), .pp3(pp3),
    .neg0(negv[0]), .neg1(negv[1]), .neg2(negv[2]), .neg3(negv[3]),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_acc(out_acc_a), .out_ovf(out_ovf_a)
  );

  pp_accumulator #(.ACC_W(16)) dut16 (
    .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_last(in_last), .pp0(pp0), .pp1(pp1), .pp2(pp2), .pp3(pp3),
    .neg0(negv[0]), .neg1(negv[1]), .neg2(negv[2]), .neg3(negv[3]),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_acc(out_acc_b), .out_ovf(out_ovf_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always begin
    @(posedge clk);
    #1;
    rnd_ready = 1'($urandom_range(0, 1));
  end

  // Handshake happens at the next rising edge; values are stable until then.
  always @(negedge clk) begin
    if (!reset && out_valid_s && out_ready) begin
      obs_acc.push_back(out_acc_s);
      obs_ovf.push_back(out_ovf_s);
      obs_cyc.push_back(cyc);
    end
  end

  // Radix-4 Booth PPG: rows carry {~s,s,s} / {~s} sign prefixes and one's complement negation.
  function automatic ppg_t ppg(input int a, input int b);
    ppg_t       r;
    logic [8:0] bx;
    logic [8:0] rows [4];
    logic [8:0] x;
    int         d, m;
    r  = '0;
    bx = {b[7:0], 1'b0};
    for (int i = 0; i < 4; i++) begin
      d = -2 * int'(bx[2*i+2]) + int'(bx[2*i+1]) + int'(bx[2*i]);
      m = (d < 0 ? -d : d) * a;
      x = m[8:0];
      if (d < 0) begin
        x = ~x;
        r.neg[i] = 1'b1;
      end
      rows[i] = x;
    end
    r.pp0 = {~rows[0][8], rows[0][8], rows[0]};
    r.pp1 = {~rows[1][8], rows[1][7:0]};
    r.pp2 = {~rows[2][8], rows[2][7:0]};
    r.pp3 = {~rows[3][8], rows[3][7:0]};
    return r;
  endfunction

  function automatic void model_beat(input int prod, input bit last);
    longint s, mx, mn;
    mx = (longint'(1) << (acc_w - 1)) - 1;
    mn = -(longint'(1) << (acc_w - 1));
    s  = m_first ? longint'(prod) : longint'(m_acc) + longint'(prod);
    if (s > mx) begin s = mx; m_ovf = 1'b1; end
    else if (s < mn) begin s = mn; m_ovf = 1'b1; end
    m_acc = int'(s);
    if (last) begin
      exp_acc.push_back(m_acc);
      exp_ovf.push_back(m_ovf);
      m_first = 1'b1;
      m_ovf   = 1'b0;
    end else begin
      m_first = 1'b0;
    end
  endfunction

  function automatic void model_reset();
    m_acc   = 0;
    m_ovf   = 1'b0;
    m_first = 1'b1;
  endfunction

  task automatic drive_beat(input int a, input int b, input bit last);
    ppg_t p;
    p = ppg(a, b);
    pp0 = p.pp0; pp1 = p.pp1; pp2 = p.pp2; pp3 = p.pp3; negv = p.neg;
    in_last = last;
    in_valid_drv = 1'b1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_beat(input int a, input int b, input bit last);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    drive_beat(a, b, last);
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready_s;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      n_checks++;
      n_err++;
      $display("FAIL send_beat: beat %0d x %0d not accepted, in_ready=%0b required 1", a, b, in_ready_s);
    end else begin
      model_beat(a * b, last);
      $display("  beat %0d x %0d last=%0b accepted at cycle %0d", a, b, last, cyc);
    end
    in_valid_drv = 1'b0;
    in_last      = 1'b0;
  endtask

  task automatic wait_results();
    int k;
    k = 0;
    while (obs_acc.size() < exp_acc.size() && k < 400) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (in_ready_s !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %0b required 1", in_ready_s); end
    n_checks++; if (out_valid_s !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %0b required 0", out_valid_s); end
    n_checks++; if (out_acc_s !== 0) begin n_err++; $display("FAIL reset_out_acc: got %0d required 0", out_acc_s); end
    n_checks++; if (out_ovf_s !== 1'b0) begin n_err++; $display("FAIL reset_out_ovf: got %0b required 0", out_ovf_s); end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    int a, e;
    bit ov, eo;
    out_ready_man = 1'b1;
    send_beat(3, 5, 1'b1);
    @(posedge clk);
    #1;
    n_checks++; if (out_valid_s !== 1'b0) begin n_err++; $display("FAIL single_early: out_valid=%0b one edge after accept, required 0", out_valid_s); end
    @(posedge clk);
    #1;
    n_checks++; if (out_valid_s !== 1'b1) begin n_err++; $display("FAIL single_latency: out_valid=%0b two edges after accept, required 1", out_valid_s); end
    n_checks++; if (out_acc_s !== 15) begin n_err++; $display("FAIL single_value: out_acc=%0d required 15", out_acc_s); end
    wait_results();
    n_checks++; if (obs_acc.size() !== exp_acc.size()) begin n_err++; $display("FAIL single_count: got %0d results required %0d", obs_acc.size(), exp_acc.size()); end
    while (obs_acc.size() > 0 && exp_acc.size() > 0) begin
      a = obs_acc.pop_front(); e = exp_acc.pop_front(); ov = obs_ovf.pop_front(); eo = exp_ovf.pop_front();
      $display("  single result acc=%0d ovf=%0b expected acc=%0d ovf=%0b", a, ov, e, eo);
      n_checks++; if (a !== e) begin n_err++; $display("FAIL single_acc: got %0d required %0d", a, e); end
      n_checks++; if (ov !== eo) begin n_err++; $display("FAIL single_ovf: got %0b required %0b", ov, eo); end
    end
    obs_cyc.delete(); obs_acc.delete(); obs_ovf.delete(); exp_acc.delete(); exp_ovf.delete();
  endtask

  task automatic test_corners();
    int a, e;
    bit ov, eo;
    send_beat(-128, -128, 1'b1);
    send_beat(-128, 127, 1'b1);
    send_beat(0, -77, 1'b1);
    wait_results();
    n_checks++; if (obs_acc.size() !== 3) begin n_err++; $display("FAIL corners_count: got %0d results required 3", obs_acc.size()); end
    if (obs_cyc.size() >= 3) begin
      n_checks++; if (obs_cyc[1] !== obs_cyc[0] + 1) begin n_err++; $display("FAIL corners_gap01: result cycles %0d,%0d required consecutive", obs_cyc[0], obs_cyc[1]); end
      n_checks++; if (obs_cyc[2] !== obs_cyc[1] + 1) begin n_err++; $display("FAIL corners_gap12: result cycles %0d,%0d required consecutive", obs_cyc[1], obs_cyc[2]); end
    end
    while (obs_acc.size() > 0 && exp_acc.size() > 0) begin
      a = obs_acc.pop_front(); e = exp_acc.pop_front(); ov = obs_ovf.pop_front(); eo = exp_ovf.pop_front();
      $display("  corner result acc=%0d ovf=%0b expected acc=%0d ovf=%0b", a, ov, e, eo);
      n_checks++; if (a !== e) begin n_err++; $display("FAIL corners_acc: got %0d required %0d", a, e); end
      n_checks++; if (ov !== eo) begin n_err++; $display("FAIL corners_ovf: got %0b required %0b", ov, eo); end
    end
    obs_cyc.delete(); obs_acc.delete(); obs_ovf.delete(); exp_acc.delete(); exp_ovf.delete();
  endtask

  task automatic test_burst4();
    int a, e;
    bit ov, eo;
    for (int i = 0; i < 4; i++) send_beat(127, 127, i == 3);
    wait_results();
    n_checks++; if (obs_acc.size() !== 1) begin n_err++; $display("FAIL burst4_count: got %0d results required 1", obs_acc.size()); end
    while (obs_acc.size() > 0 && exp_acc.size() > 0) begin
      a = obs_acc.pop_front(); e = exp_acc.pop_front(); ov = obs_ovf.pop_front(); eo = exp_ovf.pop_front();
      $display("  burst4 result acc=%0d ovf=%0b expected acc=%0d ovf=%0b", a, ov, e, eo);
      n_checks++; if (a !== e) begin n_err++; $display("FAIL burst4_acc: got %0d required %0d", a, e); end
      n_checks++; if (ov !== eo) begin n_err++; $display("FAIL burst4_ovf: got %0b required %0b", ov, eo); end
    end
    obs_cyc.delete(); obs_acc.delete(); obs_ovf.delete(); exp_acc.delete(); exp_ovf.delete();
  endtask

  task automatic test_sat16();
    int a, e;
    bit ov, eo;
    sel16 = 1'b1;
    acc_w = 16;
    for (int i = 0; i < 3; i++) send_beat(-128, -128, i == 2);
    send_beat(1, 1, 1'b1);
    wait_results();
    n_checks++; if (obs_acc.size() !== 2) begin n_err++; $display("FAIL sat16_count: got %0d results required 2", obs_acc.size()); end
    while (obs_acc.size() > 0 && exp_acc.size() > 0) begin
      a = obs_acc.pop_front(); e = exp_acc.pop_front(); ov = obs_ovf.pop_front(); eo = exp_ovf.pop_front();
      $display("  sat16 result acc=%0d ovf=%0b expected acc=%0d ovf=%0b", a, ov, e, eo);
      n_checks++; if (a !== e) begin n_err++; $display("FAIL sat16_acc: got %0d required %0d", a, e); end
      n_checks++; if (ov !== eo) begin n_err++; $display("FAIL sat16_ovf: got %0b required %0b", ov, eo); end
    end
    obs_cyc.delete(); obs_acc.delete(); obs_ovf.delete(); exp_acc.delete(); exp_ovf.delete();
    sel16 = 1'b0;
    acc_w = 20;
  endtask

  task automatic test_backpressure();
    int a, e, k;
    bit ov, eo;
    out_ready_man = 1'b0;
    send_beat(10, 20, 1'b0);
    send_beat(-3, 7, 1'b1);
    send_beat(5, 6, 1'b0);
    send_beat(-8, 9, 1'b0);
    k = 0;
    while (!out_valid_s && k < 50) begin @(posedge clk); #1; k++; end
    n_checks++; if (out_valid_s !== 1'b1) begin n_err++; $display("FAIL bp_first_valid: out_valid=%0b required 1", out_valid_s); end
    drive_beat(-100, 50, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++; if (in_ready_s !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: got %0b required 0 while stalled", in_ready_s); end
      n_checks++; if (exp_acc.size() > 0 && out_acc_s !== exp_acc[0]) begin n_err++; $display("FAIL bp_hold_acc: got %0d required %0d", out_acc_s, exp_acc[0]); end
    end
    @(posedge clk);
    #1;
    out_ready_man = 1'b1;
    send_beat(-100, 50, 1'b1);
    wait_results();
    n_checks++; if (obs_acc.size() !== 2) begin n_err++; $display("FAIL bp_count: got %0d results required 2", obs_acc.size()); end
    while (obs_acc.size() > 0 && exp_acc.size() > 0) begin
      a = obs_acc.pop_front(); e = exp_acc.pop_front(); ov = obs_ovf.pop_front(); eo = exp_ovf.pop_front();
      $display("  backpressure result acc=%0d ovf=%0b expected acc=%0d ovf=%0b", a, ov, e, eo);
      n_checks++; if (a !== e) begin n_err++; $display("FAIL bp_acc: got %0d required %0d", a, e); end
      n_checks++; if (ov !== eo) begin n_err++; $display("FAIL bp_ovf: got %0b required %0b", ov, eo); end
    end
    obs_cyc.delete(); obs_acc.delete(); obs_ovf.delete(); exp_acc.delete(); exp_ovf.delete();
  endtask

  task automatic test_random();
    int a, e, len;
    bit ov, eo;
    rand_ready = 1'b1;
    for (int bi = 0; bi < 8; bi++) begin
      len = int'($urandom_range(1, 4));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        send_beat(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128, i == len - 1);
      end
    end
    wait_results();
    n_checks++; if (obs_acc.size() !== 8) begin n_err++; $display("FAIL random_count: got %0d results required 8", obs_acc.size()); end
    while (obs_acc.size() > 0 && exp_acc.size() > 0) begin
      a = obs_acc.pop_front(); e = exp_acc.pop_front(); ov = obs_ovf.pop_front(); eo = exp_ovf.pop_front();
      $display("  random result acc=%0d ovf=%0b expected acc=%0d ovf=%0b", a, ov, e, eo);
      n_checks++; if (a !== e) begin n_err++; $display("FAIL random_acc: got %0d required %0d", a, e); end
      n_checks++; if (ov !== eo) begin n_err++; $display("FAIL random_ovf: got %0b required %0b", ov, eo); end
    end
    obs_cyc.delete(); obs_acc.delete(); obs_ovf.delete(); exp_acc.delete(); exp_ovf.delete();
    rand_ready = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int a, e;
    bit ov, eo;
    out_ready_man = 1'b1;
    send_beat(7, 7, 1'b0);
    send_beat(9, 9, 1'b0);
    reset = 1'b1;
    #1;
    n_checks++; if (in_ready_s !== 1'b1) begin n_err++; $display("FAIL rmid_in_ready: got %0b required 1", in_ready_s); end
    n_checks++; if (out_valid_s !== 1'b0) begin n_err++; $display("FAIL rmid_out_valid: got %0b required 0", out_valid_s); end
    n_checks++; if (out_acc_s !== 0) begin n_err++; $display("FAIL rmid_out_acc: got %0d required 0", out_acc_s); end
    n_checks++; if (out_ovf_s !== 1'b0) begin n_err++; $display("FAIL rmid_out_ovf: got %0b required 0", out_ovf_s); end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    send_beat(2, 3, 1'b1);
    wait_results();
    n_checks++; if (obs_acc.size() !== 1) begin n_err++; $display("FAIL rmid_count: got %0d results required 1", obs_acc.size()); end
    while (obs_acc.size() > 0 && exp_acc.size() > 0) begin
      a = obs_acc.pop_front(); e = exp_acc.pop_front(); ov = obs_ovf.pop_front(); eo = exp_ovf.pop_front();
      $display("  reset-mid result acc=%0d ovf=%0b expected acc=%0d ovf=%0b", a, ov, e, eo);
      n_checks++; if (a !== e) begin n_err++; $display("FAIL rmid_acc: got %0d required %0d", a, e); end
      n_checks++; if (ov !== eo) begin n_err++; $display("FAIL rmid_ovf: got %0b required %0b", ov, eo); end
    end
    obs_cyc.delete(); obs_acc.delete(); obs_ovf.delete(); exp_acc.delete(); exp_ovf.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_err, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_corners();
    test_burst4();
    test_sat16();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
